// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multicycle RV32I core. Decodes the op/funct fields held
// in the instruction register and steps the datapath one state per cycle,
// sharing the single ALU and memory port across fetch, execute and writeback.
// It also selects the immediate format for the extender.
//
// Ports
//   clk          in   1  core clock, all state changes on the rising edge
//   reset        in   1  synchronous active-high reset
//   op           in   7  instr[6:0]
//   funct3       in   3  instr[14:12]
//   funct7b5     in   1  instr[30]
//   zero         in   1  ALU zero flag (meaningful in BEQ)
//   pc_write     out  1  PC load enable
//   adr_src      out  1  memory address select: 0=PC, 1=ALUOut
//   mem_write    out  1  data memory write enable
//   ir_write     out  1  IR/OldPC load enable
//   result_src   out  2  00=ALUOut 01=MemData 10=ALU result 11=imm_ext
//   alu_src_a    out  2  00=PC 01=OldPC 10=rs1
//   alu_src_b    out  2  00=rs2 01=imm_ext 10=const 4
//   alu_ctrl     out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   reg_write    out  1  register file write enable
//   extend_ctrl  out  3  000 I, 001 S, 010 B, 011 U, 100 J
//   illegal      out  1  high while in TRAP
//   state        out  4  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       reg_write,
    output logic [2:0] extend_ctrl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_reg;
    state_t state_next;

    // Opcode classification
    logic is_load;
    logic is_store;
    logic is_rtype;
    logic is_itype;
    logic is_jal;
    logic is_branch;
    logic is_lui;

    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_rtype  = (op == OP_RTYPE);
    assign is_itype  = (op == OP_ITYPE);
    assign is_jal    = (op == OP_JAL);
    assign is_branch = (op == OP_BRANCH);
    assign is_lui    = (op == OP_LUI);

    // ALU operation for R/I-type execute states. Unsupported funct3 values
    // clear funct_ok so the execute state diverts to TRAP instead of ALUWB.
    logic [2:0] funct_alu_ctrl;
    logic       funct_ok;

    always_comb begin
        funct_alu_ctrl = ALU_ADD;
        funct_ok       = 1'b1;
        case (funct3)
            3'b000:  funct_alu_ctrl = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu_ctrl = ALU_SLT;
            3'b110:  funct_alu_ctrl = ALU_OR;
            3'b111:  funct_alu_ctrl = ALU_AND;
            default: funct_ok       = 1'b0;
        endcase
    end

    // Only beq (000) and bne (001) are supported; bne inverts the zero test.
    logic branch_ok;
    logic branch_taken;

    assign branch_ok    = (funct3[2:1] == 2'b00);
    assign branch_taken = branch_ok & (zero ^ funct3[0]);

    // Immediate format follows the opcode directly; it only matters once the
    // instruction register is loaded, i.e. from DECODE onward.
    logic [2:0] extend_fsm;

    always_comb begin
        extend_fsm = 3'b000;
        if (is_store) begin
            extend_fsm = 3'b001;
        end else if (is_branch) begin
            extend_fsm = 3'b010;
        end else if (is_lui) begin
            extend_fsm = 3'b011;
        end else if (is_jal) begin
            extend_fsm = 3'b100;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= state_t'(RESET_STATE);
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state outputs (before reset gating)
    logic       pc_write_fsm;
    logic       adr_src_fsm;
    logic       mem_write_fsm;
    logic       ir_write_fsm;
    logic [1:0] result_src_fsm;
    logic [1:0] alu_src_a_fsm;
    logic [1:0] alu_src_b_fsm;
    logic [2:0] alu_ctrl_fsm;
    logic       reg_write_fsm;
    logic       illegal_fsm;

    always_comb begin
        state_next     = state_reg;
        pc_write_fsm   = 1'b0;
        adr_src_fsm    = 1'b0;
        mem_write_fsm  = 1'b0;
        ir_write_fsm   = 1'b0;
        result_src_fsm = 2'b00;
        alu_src_a_fsm  = 2'b00;
        alu_src_b_fsm  = 2'b00;
        alu_ctrl_fsm   = ALU_ADD;
        reg_write_fsm  = 1'b0;
        illegal_fsm    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Fetch the instruction and compute PC+4 on the ALU
                adr_src_fsm    = 1'b0;
                ir_write_fsm   = 1'b1;
                alu_src_a_fsm  = 2'b00;
                alu_src_b_fsm  = 2'b10;
                alu_ctrl_fsm   = ALU_ADD;
                result_src_fsm = 2'b10;
                pc_write_fsm   = 1'b1;
                state_next     = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target OldPC + imm while decoding
                alu_src_a_fsm = 2'b01;
                alu_src_b_fsm = 2'b01;
                alu_ctrl_fsm  = ALU_ADD;
                if (is_load || is_store) begin
                    state_next = S_MEMADR;
                end else if (is_rtype) begin
                    state_next = S_EXECR;
                end else if (is_itype) begin
                    state_next = S_EXECI;
                end else if (is_jal) begin
                    state_next = S_JAL;
                end else if (is_branch) begin
                    state_next = S_BEQ;
                end else if (is_lui) begin
                    state_next = S_LUI;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEMADR: begin
                alu_src_a_fsm = 2'b10;
                alu_src_b_fsm = 2'b01;
                alu_ctrl_fsm  = ALU_ADD;
                // op[5] separates store (0100011) from load (0000011)
                state_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_fsm = 1'b1;
                state_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_fsm = 2'b01;
                reg_write_fsm  = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_fsm   = 1'b1;
                mem_write_fsm = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_fsm = 2'b10;
                alu_src_b_fsm = 2'b00;
                alu_ctrl_fsm  = funct_alu_ctrl;
                state_next    = funct_ok ? S_ALUWB : S_TRAP;
            end
            S_EXECI: begin
                alu_src_a_fsm = 2'b10;
                alu_src_b_fsm = 2'b01;
                alu_ctrl_fsm  = funct_alu_ctrl;
                state_next    = funct_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                result_src_fsm = 2'b00;
                reg_write_fsm  = 1'b1;
                state_next     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut from DECODE while the
                // ALU forms OldPC + 4 for the link register written in ALUWB.
                alu_src_a_fsm  = 2'b01;
                alu_src_b_fsm  = 2'b10;
                alu_ctrl_fsm   = ALU_ADD;
                result_src_fsm = 2'b00;
                pc_write_fsm   = 1'b1;
                state_next     = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a_fsm  = 2'b10;
                alu_src_b_fsm  = 2'b00;
                alu_ctrl_fsm   = ALU_SUB;
                result_src_fsm = 2'b00;
                pc_write_fsm   = branch_taken;
                state_next     = branch_ok ? S_FETCH : S_TRAP;
            end
            S_LUI: begin
                result_src_fsm = 2'b11;
                reg_write_fsm  = 1'b1;
                state_next     = S_FETCH;
            end
            S_TRAP: begin
                illegal_fsm = 1'b1;
                state_next  = S_TRAP;
            end
            default: begin
                // Unused encodings are treated as a fault
                illegal_fsm = 1'b1;
                state_next  = S_TRAP;
            end
        endcase
    end

    // While reset is high everything is forced quiet, so an instruction
    // interrupted by reset can never complete a write in that cycle.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_ctrl    = 3'b000;
        reg_write   = 1'b0;
        extend_ctrl = 3'b000;
        illegal     = 1'b0;
        if (!reset) begin
            pc_write    = pc_write_fsm;
            adr_src     = adr_src_fsm;
            mem_write   = mem_write_fsm;
            ir_write    = ir_write_fsm;
            result_src  = result_src_fsm;
            alu_src_a   = alu_src_a_fsm;
            alu_src_b   = alu_src_b_fsm;
            alu_ctrl    = alu_ctrl_fsm;
            reg_write   = reg_write_fsm;
            extend_ctrl = extend_fsm;
            illegal     = illegal_fsm;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed testbench for multicycle_controller. Each task drives one
// instruction or scenario and checks state and control outputs cycle by
// cycle against hand-derived expectations. Outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic [2:0] extend_ctrl;
    logic       illegal;
    logic [3:0] state;

    int total;
    int bad;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .reg_write  (reg_write),
        .extend_ctrl(extend_ctrl),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({pc_write, mem_write, ir_write, reg_write, illegal} !== 5'b0) begin
                bad++;
                $display("FAIL reset_quiet cyc=%0d got=%b want=00000", i,
                         {pc_write, mem_write, ir_write, reg_write, illegal});
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d want=0", state);
        end
        total++;
        if ({pc_write, ir_write, adr_src, alu_src_b, result_src} !== 7'b1101010) begin
            bad++;
            $display("FAIL reset_fetch got=%b want=1101010",
                     {pc_write, ir_write, adr_src, alu_src_b, result_src});
        end
        $display("reset: released into FETCH state=%0d", state);
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [5];
        logic       exp_rw;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_rw = (i == 4);
            total++;
            if (state !== exp_st[i]) begin
                bad++;
                $display("FAIL lw_state cyc=%0d got=%0d want=%0d", i, state, exp_st[i]);
            end
            total++;
            if (reg_write !== exp_rw || mem_write !== 1'b0) begin
                bad++;
                $display("FAIL lw_writes cyc=%0d got rw=%b mw=%b want rw=%b mw=0",
                         i, reg_write, mem_write, exp_rw);
            end
            if (i == 2) begin
                total++;
                if ({alu_src_a, alu_src_b, alu_ctrl} !== 7'b1001000) begin
                    bad++;
                    $display("FAIL lw_memadr got=%b want=1001000",
                             {alu_src_a, alu_src_b, alu_ctrl});
                end
            end
            if (i == 3) begin
                total++;
                if (adr_src !== 1'b1) begin
                    bad++;
                    $display("FAIL lw_adr_src got=%b want=1", adr_src);
                end
            end
            if (i == 4) begin
                total++;
                if (result_src !== 2'b01) begin
                    bad++;
                    $display("FAIL lw_result_src got=%b want=01", result_src);
                end
            end
            step();
        end
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL lw_return got=%0d want=0", state);
        end
        $display("lw: 5-cycle sequence completed");
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [4];
        logic       exp_mw;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_mw = (i == 3);
            total++;
            if (state !== exp_st[i]) begin
                bad++;
                $display("FAIL sw_state cyc=%0d got=%0d want=%0d", i, state, exp_st[i]);
            end
            total++;
            if (mem_write !== exp_mw || reg_write !== 1'b0) begin
                bad++;
                $display("FAIL sw_writes cyc=%0d got mw=%b rw=%b want mw=%b rw=0",
                         i, mem_write, reg_write, exp_mw);
            end
            if (i >= 1) begin
                total++;
                if (extend_ctrl !== 3'b001) begin
                    bad++;
                    $display("FAIL sw_extend cyc=%0d got=%b want=001", i, extend_ctrl);
                end
            end
            if (i == 3) begin
                total++;
                if (adr_src !== 1'b1) begin
                    bad++;
                    $display("FAIL sw_adr_src got=%b want=1", adr_src);
                end
            end
            step();
        end
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL sw_return got=%0d want=0", state);
        end
        $display("sw: 4-cycle sequence completed");
    endtask

    // Runs one branch; f3/z select beq/bne and the zero flag.
    task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pcw);
        op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0; zero = z;
        step();
        step();
        total++;
        if (state !== 4'd10) begin
            bad++;
            $display("FAIL br_state f3=%b got=%0d want=10", f3, state);
        end
        total++;
        if (pc_write !== exp_pcw) begin
            bad++;
            $display("FAIL br_pc_write f3=%b zero=%b got=%b want=%b", f3, z, pc_write, exp_pcw);
        end
        total++;
        if ({alu_ctrl, extend_ctrl, alu_src_a} !== 8'b00101010) begin
            bad++;
            $display("FAIL br_ctrl got=%b want=00101010", {alu_ctrl, extend_ctrl, alu_src_a});
        end
        step();
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL br_return got=%0d want=0", state);
        end
        $display("branch: funct3=%b zero=%b pc_write=%b", f3, z, exp_pcw);
    endtask

    // R/I-type: checks execute state, ALU op and the ALUWB writeback.
    task automatic test_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [3:0] exp_exec, input logic [2:0] exp_alu,
                            input logic [1:0] exp_b);
        op = o; funct3 = f3; funct7b5 = f7; zero = 1'b0;
        step();
        step();
        total++;
        if (state !== exp_exec) begin
            bad++;
            $display("FAIL alu_exec_state got=%0d want=%0d", state, exp_exec);
        end
        total++;
        if ({alu_ctrl, alu_src_a, alu_src_b, reg_write} !== {exp_alu, 2'b10, exp_b, 1'b0}) begin
            bad++;
            $display("FAIL alu_exec_ctrl got=%b want=%b",
                     {alu_ctrl, alu_src_a, alu_src_b, reg_write}, {exp_alu, 2'b10, exp_b, 1'b0});
        end
        step();
        total++;
        if (state !== 4'd7 || reg_write !== 1'b1 || result_src !== 2'b00) begin
            bad++;
            $display("FAIL alu_wb got st=%0d rw=%b rs=%b want st=7 rw=1 rs=00",
                     state, reg_write, result_src);
        end
        step();
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL alu_return got=%0d want=0", state);
        end
        $display("alu: op=%b funct3=%b f7b5=%b alu_ctrl=%b", o, f3, f7, exp_alu);
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        step();
        total++;
        if (extend_ctrl !== 3'b100) begin
            bad++;
            $display("FAIL jal_extend got=%b want=100", extend_ctrl);
        end
        step();
        total++;
        if (state !== 4'd9 || pc_write !== 1'b1 || reg_write !== 1'b0) begin
            bad++;
            $display("FAIL jal_state got st=%0d pcw=%b rw=%b want st=9 pcw=1 rw=0",
                     state, pc_write, reg_write);
        end
        total++;
        if ({alu_src_a, alu_src_b} !== 4'b0110) begin
            bad++;
            $display("FAIL jal_mux got=%b want=0110", {alu_src_a, alu_src_b});
        end
        step();
        total++;
        if (state !== 4'd7 || reg_write !== 1'b1) begin
            bad++;
            $display("FAIL jal_wb got st=%0d rw=%b want st=7 rw=1", state, reg_write);
        end
        step();
        $display("jal: 4-cycle sequence completed");
    endtask

    task automatic test_lui();
        op = 7'b0110111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        step();
        step();
        total++;
        if (state !== 4'd11 || reg_write !== 1'b1 || result_src !== 2'b11 || extend_ctrl !== 3'b011) begin
            bad++;
            $display("FAIL lui_wb got st=%0d rw=%b rs=%b ext=%b want st=11 rw=1 rs=11 ext=011",
                     state, reg_write, result_src, extend_ctrl);
        end
        step();
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL lui_return got=%0d want=0", state);
        end
        $display("lui: 3-cycle sequence completed");
    endtask

    // Enters TRAP via the given op/funct3 after n_pre cycles, then holds.
    task automatic test_trap(input logic [6:0] o, input logic [2:0] f3, input int n_pre);
        op = o; funct3 = f3; funct7b5 = 1'b0; zero = 1'b1;
        for (int i = 0; i < n_pre; i++) step();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (state !== 4'd12 || illegal !== 1'b1 ||
                {pc_write, mem_write, ir_write, reg_write} !== 4'b0) begin
                bad++;
                $display("FAIL trap_hold cyc=%0d got st=%0d ill=%b en=%b want st=12 ill=1 en=0000",
                         i, state, illegal, {pc_write, mem_write, ir_write, reg_write});
            end
            step();
        end
        reset = 1'b1;
        #1;
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL trap_reset_illegal got=%b want=0", illegal);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || illegal !== 1'b0 || ir_write !== 1'b1) begin
            bad++;
            $display("FAIL trap_recover got st=%0d ill=%b irw=%b want st=0 ill=0 irw=1",
                     state, illegal, ir_write);
        end
        $display("trap: op=%b funct3=%b held 10 cycles, reset recovered", o, f3);
    endtask

    task automatic test_reset_memwrite();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        step();
        step();
        step();
        total++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            bad++;
            $display("FAIL rmw_pre got st=%0d mw=%b want st=5 mw=1", state, mem_write);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_write !== 1'b0) begin
            bad++;
            $display("FAIL rmw_mem_write got=%b want=0", mem_write);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL rmw_state got=%0d want=0", state);
        end
        $display("reset_memwrite: store abandoned, back in FETCH");
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        test_reset();
        test_lw();
        test_sw();
        test_branch(3'b000, 1'b1, 1'b1);   // beq taken
        test_branch(3'b001, 1'b1, 1'b0);   // bne not taken
        test_branch(3'b001, 1'b0, 1'b1);   // bne taken
        test_alu(7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001, 2'b00);  // sub
        test_alu(7'b0110011, 3'b111, 1'b0, 4'd6, 3'b010, 2'b00);  // and
        test_alu(7'b0010011, 3'b000, 1'b1, 4'd8, 3'b000, 2'b01);  // addi, f7b5 ignored
        test_alu(7'b0010011, 3'b110, 1'b0, 4'd8, 3'b011, 2'b01);  // ori
        test_alu(7'b0010011, 3'b010, 1'b0, 4'd8, 3'b101, 2'b01);  // slti
        test_jal();
        test_lui();
        test_trap(7'b1111111, 3'b000, 2);  // unknown opcode
        test_trap(7'b0110011, 3'b001, 3);  // R-type unsupported funct3
        test_trap(7'b1100011, 3'b100, 3);  // unsupported branch
        test_reset_memwrite();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
